sevenseg_scan: RTL and testbench

Output-side counterpart to the push-button input conditioner in the divider demo. It drives a 4-digit common-anode seven-segment display by time-multiplexing digits. It shows a 16-bit value as four hex digits with per-digit decimal points and optional leading-zero blanking. New display data is double-buffered and applied only at a frame boundary, so a scan never shows a torn value.

---
 rtl/sevenseg_scan.sv | 169 ++++++++++++++++
 tb/tb_sevenseg_scan.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan
// Drives a 4-digit common-anode seven-segment display by time-multiplexing
// the digits. A 16-bit value is shown as four hex digits, with a decimal
// point per digit and optional leading-zero blanking. New data is held in a
// pending buffer and copied to the active buffer only at a frame boundary,
// so one scan never mixes old and new digits.
//
// Parameters:
//   CLK_DIV  clock cycles per digit slot (must be >= GUARD+2)
//   GUARD    cycles at the start of each slot with every anode off
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   value     display data, value[15:12] is digit 3 (leftmost)
//   dp        decimal-point request, dp[i] belongs to digit i
//   blank_lz  leading-zero blanking enable
//   load      one-cycle strobe that captures value/dp/blank_lz as pending
//   an        digit anodes, active-low, an[i] is digit i
//   seg       segments a..g on seg[0]..seg[6], active-low
//   dp_n      decimal point, active-low
//   frame     one-cycle pulse on the first output cycle of a frame that
//             uses freshly applied data
module sevenseg_scan #(
  parameter int CLK_DIV = 100000,
  parameter int GUARD   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          slot_end;
  logic          frame_edge;

  logic [15:0]   pend_value;
  logic [3:0]    pend_dp;
  logic          pend_blz;
  logic          pend_flag;
  logic [15:0]   act_value;
  logic [3:0]    act_dp;
  logic          act_blz;
  logic          applied;

  logic [3:0]    nibble;
  logic [3:0]    blank_vec;
  logic          cur_blank;
  logic          cur_dp;
  logic          guard_done;
  logic [6:0]    glyph;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  assign slot_end   = (cnt == CW'(CLK_DIV - 1));
  assign frame_edge = slot_end && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load on the boundary cycle must not be lost: the old pending data moves
  // to active while the new data lands in pending with the flag kept set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blz   <= 1'b0;
      pend_flag  <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blz    <= 1'b0;
      applied    <= 1'b0;
    end else begin
      applied <= frame_edge && pend_flag;
      if (frame_edge && pend_flag) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_blz   <= pend_blz;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blz   <= blank_lz;
        pend_flag  <= 1'b1;
      end else if (frame_edge) begin
        pend_flag  <= 1'b0;
      end
    end
  end

  // Blanking cascades from the left: a digit can only be blank if every
  // digit to its left is blank too. Digit 0 always shows.
  always_comb begin
    nibble       = act_value[{idx, 2'b00} +: 4];
    blank_vec    = 4'b0000;
    blank_vec[3] = act_blz && (act_value[15:12] == 4'h0);
    blank_vec[2] = blank_vec[3] && (act_value[11:8] == 4'h0);
    blank_vec[1] = blank_vec[2] && (act_value[7:4] == 4'h0);
    cur_blank    = blank_vec[idx];
    cur_dp       = act_dp[idx];
    guard_done   = int'(cnt) >= GUARD;
  end

  always_comb begin
    glyph = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'h7F;
    endcase
  end

  // A blank digit still lights its anode when its decimal point is wanted,
  // so the dot remains visible with the segments off.
  always_comb begin
    an_next = 4'hF;
    if (guard_done && (!cur_blank || cur_dp)) begin
      an_next[idx] = 1'b0;
    end
    seg_next = cur_blank ? 7'h7F : glyph;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= 4'hF;
      seg   <= 7'h7F;
      dp_n  <= 1'b1;
      frame <= 1'b0;
    end else begin
      an    <= an_next;
      seg   <= seg_next;
      dp_n  <= ~cur_dp;
      frame <= applied;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan
// Self-checking bench for sevenseg_scan with CLK_DIV=8, GUARD=2. A reference
// model predicts every output cycle from a log of accepted loads: the cycle
// number since reset fixes the digit, slot offset and frame number, and the
// last load before the frame's boundary gives the data on display.
module tb_sevenseg_scan;

  localparam int CD = 8;
  localparam int G  = 2;
  localparam int FP = 4 * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame;

  typedef struct {
    int          e;
    logic [15:0] v;
    logic [3:0]  d;
    logic        b;
  } ld_t;

  ld_t lq[$];
  int  ecount = 0;
  int  checks = 0;
  int  fails  = 0;

  sevenseg_scan #(.CLK_DIV(CD), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank_lz(blank_lz),
    .load(load), .an(an), .seg(seg), .dp_n(dp_n), .frame(frame)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; read at the falling edge it equals the
  // number of the edge that produced the outputs being observed.
  always @(posedge clk) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected {an, seg, dp_n, frame} after edge e of the current reset epoch.
  function automatic logic [12:0] model_out(input int e);
    int          p, f, digit, off;
    logic [15:0] v;
    logic [3:0]  d, a;
    logic        b, blank, lit, fr;
    logic [6:0]  s;
    if (e == 0) return {4'hF, 7'h7F, 1'b1, 1'b0};
    p = e - 1;
    f = p / FP;
    digit = (p / CD) % 4;
    off = p % CD;
    v = '0; d = '0; b = 1'b0; fr = 1'b0;
    foreach (lq[i]) begin
      if (lq[i].e < f * FP) begin
        v = lq[i].v; d = lq[i].d; b = lq[i].b;
      end
      if (f >= 1 && lq[i].e >= (f - 1) * FP && lq[i].e < f * FP) fr = 1'b1;
    end
    fr = fr && (off == 0) && (digit == 0);
    blank = b && (digit > 0) && ((v >> (4 * digit)) == 16'h0);
    lit = (!blank || d[digit]) && (off >= G);
    a = 4'hF;
    if (lit) a = ~(4'b0001 << digit);
    s = blank ? 7'h7F : glyph_of(v[4 * digit +: 4]);
    return {a, s, ~d[digit], fr};
  endfunction

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic b);
    ld_t x;
    value = v; dp = d; blank_lz = b; load = 1'b1;
    if (!rst) begin
      x.e = ecount + 1; x.v = v; x.d = d; x.b = b;
      lq.push_back(x);
    end
  endtask

  task automatic sync_frame();
    while (ecount % FP != 0) @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses = 0;
    logic [12:0] exp;
    @(negedge clk);
    rst = 1'b1;
    lq.delete();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({an, seg, dp_n, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_values: got %h expected %h", {an, seg, dp_n, frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * FP; i++) begin
      @(negedge clk);
      exp = model_out(ecount);
      checks++;
      if ({an, seg, dp_n, frame} !== exp) begin
        fails++;
        $display("[TB] FAIL reset_scan cyc %0d: got %h expected %h", i, {an, seg, dp_n, frame}, exp);
      end
      if (frame) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      fails++;
      $display("[TB] FAIL reset_scan_frames: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_load_apply();
    int pulses = 0, lit2 = 0;
    logic [12:0] exp;
    sync_frame();
    for (int i = 0; i < 3 * FP; i++) begin
      @(negedge clk);
      exp = model_out(ecount);
      checks++;
      if ({an, seg, dp_n, frame} !== exp) begin
        fails++;
        $display("[TB] FAIL load_apply cyc %0d: got %h expected %h", i, {an, seg, dp_n, frame}, exp);
      end
      if (frame) pulses++;
      if (i >= 32 && i < 64 && an == 4'b1011 && seg == 7'b0001000 && dp_n == 1'b0) lit2++;
      load = 1'b0;
      if (i == 10) drive_load(16'h1A3F, 4'b0100, 1'b0);
    end
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("[TB] FAIL load_apply_frames: got %0d expected 1", pulses);
    end
    checks++;
    if (lit2 !== CD - G) begin
      fails++;
      $display("[TB] FAIL load_apply_digit2: got %0d lit cycles expected %0d", lit2, CD - G);
    end
  endtask

  task automatic test_blanking(input logic [3:0] d, input int want_d3);
    int bad = 0, d3 = 0;
    logic [12:0] exp;
    sync_frame();
    for (int i = 0; i < 3 * FP; i++) begin
      @(negedge clk);
      exp = model_out(ecount);
      checks++;
      if ({an, seg, dp_n, frame} !== exp) begin
        fails++;
        $display("[TB] FAIL blanking dp=%b cyc %0d: got %h expected %h", d, i, {an, seg, dp_n, frame}, exp);
      end
      if (i >= 32 && i < 64) begin
        if (an == 4'b1110 && seg != 7'b0010010) bad++;
        if (an == 4'b1101 || an == 4'b1011) bad++;
        if (an == 4'b0111) begin
          if (seg == 7'b1111111 && dp_n == 1'b0) d3++;
          else bad++;
        end
      end
      load = 1'b0;
      if (i == 1) drive_load(16'h0005, d, 1'b1);
    end
    checks++;
    if (bad !== 0 || d3 !== want_d3) begin
      fails++;
      $display("[TB] FAIL blanking_lit dp=%b: got bad=%0d d3=%0d expected bad=0 d3=%0d", d, bad, d3, want_d3);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, bad = 0;
    logic [12:0] exp;
    sync_frame();
    for (int i = 0; i < 3 * FP; i++) begin
      @(negedge clk);
      exp = model_out(ecount);
      checks++;
      if ({an, seg, dp_n, frame} !== exp) begin
        fails++;
        $display("[TB] FAIL collision cyc %0d: got %h expected %h", i, {an, seg, dp_n, frame}, exp);
      end
      if (frame) pulses++;
      if (an != 4'hF && i >= 32 && i < 64 && seg != 7'b1111001) bad++;
      if (an != 4'hF && i >= 64 && seg != 7'b0100100) bad++;
      load = 1'b0;
      if (i == 5) drive_load(16'h1111, 4'b0000, 1'b0);
      if (i == 30) drive_load(16'h2222, 4'b0000, 1'b0);
    end
    checks++;
    if (pulses !== 2 || bad !== 0) begin
      fails++;
      $display("[TB] FAIL collision_frames: got pulses=%0d bad=%0d expected pulses=2 bad=0", pulses, bad);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [12:0] exp;
    sync_frame();
    for (int i = 0; i < 3 * FP; i++) begin
      @(negedge clk);
      exp = model_out(ecount);
      checks++;
      if ({an, seg, dp_n, frame} !== exp) begin
        fails++;
        $display("[TB] FAIL reset_mid cyc %0d: got %h expected %h", i, {an, seg, dp_n, frame}, exp);
      end
      if (i == 21) begin
        checks++;
        if ({an, seg, dp_n, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
          fails++;
          $display("[TB] FAIL reset_mid_values: got %h expected %h", {an, seg, dp_n, frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
      end
      if (frame) pulses++;
      load = 1'b0;
      if (i == 1) drive_load(16'hBEEF, 4'hF, 1'b0);
      if (i == 20) begin
        rst = 1'b1;
        lq.delete();
        drive_load(16'hDEAD, 4'hF, 1'b1);
      end
      if (i == 21) rst = 1'b0;
    end
    checks++;
    if (pulses !== 0) begin
      fails++;
      $display("[TB] FAIL reset_mid_frames: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_overwrite();
    int pulses = 0, bad = 0;
    logic [12:0] exp;
    sync_frame();
    for (int i = 0; i < 3 * FP; i++) begin
      @(negedge clk);
      exp = model_out(ecount);
      checks++;
      if ({an, seg, dp_n, frame} !== exp) begin
        fails++;
        $display("[TB] FAIL overwrite cyc %0d: got %h expected %h", i, {an, seg, dp_n, frame}, exp);
      end
      if (frame) pulses++;
      if (i >= 32 && an == 4'b1110 && seg != 7'b0010010) bad++;
      load = 1'b0;
      if (i == 3)  drive_load(16'h0003, 4'b0000, 1'b0);
      if (i == 10) drive_load(16'h0004, 4'b0000, 1'b0);
      if (i == 17) drive_load(16'h0005, 4'b0000, 1'b0);
    end
    checks++;
    if (pulses !== 1 || bad !== 0) begin
      fails++;
      $display("[TB] FAIL overwrite_frames: got pulses=%0d bad=%0d expected pulses=1 bad=0", pulses, bad);
    end
  endtask

  task automatic test_random();
    int multi = 0;
    logic [12:0] exp;
    for (int i = 0; i < 270; i++) begin
      @(negedge clk);
      exp = model_out(ecount);
      checks++;
      if ({an, seg, dp_n, frame} !== exp) begin
        fails++;
        $display("[TB] FAIL random cyc %0d: got %h expected %h", i, {an, seg, dp_n, frame}, exp);
      end
      if ($countones(~an) > 1) multi++;
      load = 1'b0;
      if (i < 200 && $urandom_range(0, 7) == 0)
        drive_load(16'($urandom), 4'($urandom), 1'($urandom));
    end
    checks++;
    if (multi !== 0) begin
      fails++;
      $display("[TB] FAIL random_one_anode: got %0d overlap cycles expected 0", multi);
    end
  endtask

  initial begin
    $display("[TB] sevenseg_scan bench starting");
    test_reset();
    test_load_apply();
    test_blanking(4'b0000, 0);
    test_blanking(4'b1000, CD - G);
    test_back_to_back();
    test_reset_mid();
    test_overwrite();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
